// File: rtl/bfly_r2_pipe_if.sv
// rtl/bfly_r2_pipe_if.sv - sample/twiddle inputs and butterfly results of bfly_r2_pipe
interface bfly_r2_pipe_if #(
    parameter int DW = 16,
    parameter int TW = 16
);
    logic                 en;
    logic                 in_valid;
    logic                 inv;
    logic                 scale;
    logic                 ovf_clr;
    logic signed [DW-1:0] ar, ai, br, bi;
    logic signed [TW-1:0] wr, wi;
    logic                 out_valid;
    logic                 ovf;
    logic signed [DW-1:0] xr, xi, yr, yi;

    modport master (
        output en, in_valid, inv, scale, ovf_clr, ar, ai, br, bi, wr, wi,
        input  out_valid, ovf, xr, xi, yr, yi
    );

    modport slave (
        input  en, in_valid, inv, scale, ovf_clr, ar, ai, br, bi, wr, wi,
        output out_valid, ovf, xr, xi, yr, yi
    );
endinterface

// File: rtl/bfly_r2_pipe.sv
// rtl/bfly_r2_pipe.sv - pipelined radix-2 DIT butterfly with per-sample inverse, scaling and saturation
module bfly_r2_pipe #(
    parameter int DW = 16,
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    bfly_r2_pipe_if.slave bus
);
    localparam int PW = DW + TW;
    localparam int ZW = PW + 1;
    localparam int RW = DW + 2;
    localparam int SW = DW + 3;

    localparam logic signed [TW-1:0] W_MAX = {1'b0, {(TW-1){1'b1}}};
    localparam logic signed [TW-1:0] W_MIN = {1'b1, {(TW-1){1'b0}}};
    localparam logic signed [ZW-1:0] RND   = {{(ZW-TW+1){1'b0}}, 1'b1, {(TW-2){1'b0}}};
    localparam logic signed [SW-1:0] S_MAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] S_MIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [DW-1:0] D_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] D_MIN = {1'b1, {(DW-1){1'b0}}};

    function automatic logic signed [SW-1:0] scl(input logic signed [SW-1:0] v, input logic s);
        return s ? ((v + SW'(1)) >>> 1) : v;
    endfunction

    function automatic logic clip(input logic signed [SW-1:0] v);
        return (v > S_MAX) || (v < S_MIN);
    endfunction

    function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] v);
        if (v > S_MAX) return D_MAX;
        if (v < S_MIN) return D_MIN;
        return DW'(v);
    endfunction

    logic                 s1_v_q, s1_scale_q;
    logic signed [DW-1:0] s1_ar_q, s1_ai_q, s1_br_q, s1_bi_q;
    logic signed [TW-1:0] s1_wr_q, s1_wi_q, s1_wi_d;

    logic                 s2_v_q, s2_scale_q;
    logic signed [DW-1:0] s2_ar_q, s2_ai_q;
    logic signed [PW-1:0] s2_prr_q, s2_pii_q, s2_pri_q, s2_pir_q;
    logic signed [PW-1:0] s2_prr_d, s2_pii_d, s2_pri_d, s2_pir_d;

    logic                 s3_v_q, s3_scale_q;
    logic signed [DW-1:0] s3_ar_q, s3_ai_q;
    logic signed [RW-1:0] s3_zr_q, s3_zi_q, s3_zr_d, s3_zi_d;
    logic signed [ZW-1:0] zr, zi;

    logic                 s4_v_q;
    logic signed [SW-1:0] s4_xr_q, s4_xi_q, s4_yr_q, s4_yi_q;
    logic signed [SW-1:0] s4_xr_d, s4_xi_d, s4_yr_d, s4_yi_d;

    logic                 out_valid_q, ovf_q, ovf_d, ovf_evt;
    logic signed [DW-1:0] xr_q, xi_q, yr_q, yi_q;

    always_comb begin
        // Conjugating the most negative twiddle would wrap, so it clamps to +max.
        s1_wi_d = bus.wi;
        if (bus.inv) s1_wi_d = (bus.wi == W_MIN) ? W_MAX : -bus.wi;

        s2_prr_d = PW'(s1_br_q) * PW'(s1_wr_q);
        s2_pii_d = PW'(s1_bi_q) * PW'(s1_wi_q);
        s2_pri_d = PW'(s1_br_q) * PW'(s1_wi_q);
        s2_pir_d = PW'(s1_bi_q) * PW'(s1_wr_q);

        zr      = ZW'(s2_prr_q) - ZW'(s2_pii_q);
        zi      = ZW'(s2_pri_q) + ZW'(s2_pir_q);
        s3_zr_d = RW'((zr + RND) >>> (TW - 1));
        s3_zi_d = RW'((zi + RND) >>> (TW - 1));

        s4_xr_d = scl(SW'(s3_ar_q) + SW'(s3_zr_q), s3_scale_q);
        s4_xi_d = scl(SW'(s3_ai_q) + SW'(s3_zi_q), s3_scale_q);
        s4_yr_d = scl(SW'(s3_ar_q) - SW'(s3_zr_q), s3_scale_q);
        s4_yi_d = scl(SW'(s3_ai_q) - SW'(s3_zi_q), s3_scale_q);

        // A clip only counts for a real sample that actually advances this cycle.
        ovf_evt = s4_v_q && bus.en &&
                  (clip(s4_xr_q) || clip(s4_xi_q) || clip(s4_yr_q) || clip(s4_yi_q));
        ovf_d   = ovf_evt || (ovf_q && !bus.ovf_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;  s1_scale_q <= 1'b0;
            s1_ar_q <= '0;   s1_ai_q <= '0;  s1_br_q <= '0;  s1_bi_q <= '0;
            s1_wr_q <= '0;   s1_wi_q <= '0;
            s2_v_q <= 1'b0;  s2_scale_q <= 1'b0;  s2_ar_q <= '0;  s2_ai_q <= '0;
            s2_prr_q <= '0;  s2_pii_q <= '0;  s2_pri_q <= '0;  s2_pir_q <= '0;
            s3_v_q <= 1'b0;  s3_scale_q <= 1'b0;  s3_ar_q <= '0;  s3_ai_q <= '0;
            s3_zr_q <= '0;   s3_zi_q <= '0;
            s4_v_q <= 1'b0;
            s4_xr_q <= '0;   s4_xi_q <= '0;  s4_yr_q <= '0;  s4_yi_q <= '0;
            out_valid_q <= 1'b0;  ovf_q <= 1'b0;
            xr_q <= '0;  xi_q <= '0;  yr_q <= '0;  yi_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            if (bus.en) begin
                s1_v_q   <= bus.in_valid;  s1_scale_q <= bus.scale;
                s1_ar_q  <= bus.ar;  s1_ai_q <= bus.ai;  s1_br_q <= bus.br;  s1_bi_q <= bus.bi;
                s1_wr_q  <= bus.wr;  s1_wi_q <= s1_wi_d;

                s2_v_q   <= s1_v_q;    s2_scale_q <= s1_scale_q;
                s2_ar_q  <= s1_ar_q;   s2_ai_q    <= s1_ai_q;
                s2_prr_q <= s2_prr_d;  s2_pii_q   <= s2_pii_d;
                s2_pri_q <= s2_pri_d;  s2_pir_q   <= s2_pir_d;

                s3_v_q   <= s2_v_q;    s3_scale_q <= s2_scale_q;
                s3_ar_q  <= s2_ar_q;   s3_ai_q    <= s2_ai_q;
                s3_zr_q  <= s3_zr_d;   s3_zi_q    <= s3_zi_d;

                s4_v_q   <= s3_v_q;
                s4_xr_q  <= s4_xr_d;   s4_xi_q <= s4_xi_d;
                s4_yr_q  <= s4_yr_d;   s4_yi_q <= s4_yi_d;

                out_valid_q <= s4_v_q;
                xr_q <= sat(s4_xr_q);  xi_q <= sat(s4_xi_q);
                yr_q <= sat(s4_yr_q);  yi_q <= sat(s4_yi_q);
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.ovf       = ovf_q;
    assign bus.xr        = xr_q;
    assign bus.xi        = xi_q;
    assign bus.yr        = yr_q;
    assign bus.yi        = yi_q;
endmodule

// File: tb/tb_bfly_r2_pipe.sv
// tb/tb_bfly_r2_pipe.sv - scoreboard bench for bfly_r2_pipe with directed vectors
module tb_bfly_r2_pipe;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bfly_r2_pipe_if #(.DW(16), .TW(16)) bus ();
    bfly_r2_pipe #(.DW(16), .TW(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [15:0] xr, xi, yr, yi;
        int          at;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   ecyc   = 0;

    always @(posedge clk) if (bus.en) ecyc <= ecyc + 1;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input string nm,
                         input logic [15:0] a_r, a_i, b_r, b_i, w_r, w_i,
                         input logic inv_m, scl_m,
                         input logic [15:0] x_r, x_i, y_r, y_i);
        exp_t e;
        bus.in_valid = 1'b1;
        bus.ar = a_r;  bus.ai = a_i;  bus.br = b_r;  bus.bi = b_i;
        bus.wr = w_r;  bus.wi = w_i;  bus.inv = inv_m;  bus.scale = scl_m;
        e.xr = x_r;  e.xi = x_i;  e.yr = y_r;  e.yi = y_i;
        e.at = ecyc + 5;
        e.name = nm;
        sbq.push_back(e);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 50) begin
            step();
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d samples outstanding, expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic pulse_clr();
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
    endtask

    // Scoreboard monitor: a transfer is out_valid && en, sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.en) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got sample %h %h %h %h, expected none",
                             bus.xr, bus.xi, bus.yr, bus.yi);
                end else begin
                    e = sbq.pop_front();
                    chk({e.name, "_data"}, {bus.xr, bus.xi, bus.yr, bus.yi}, {e.xr, e.xi, e.yr, e.yi});
                    chk({e.name, "_lat"}, 80'(ecyc), 80'(e.at));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.en = 1'b1;  bus.in_valid = 1'b0;  bus.inv = 1'b0;  bus.scale = 1'b0;
        bus.ovf_clr = 1'b0;
        bus.ar = '0;  bus.ai = '0;  bus.br = '0;  bus.bi = '0;  bus.wr = '0;  bus.wi = '0;
        #12;
        chk("reset_state", {bus.out_valid, bus.ovf, bus.xr, bus.xi, bus.yr, bus.yi}, 80'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        issue("basic", 16'h1000, 16'h0, 16'h0800, 16'h0, 16'h7FFF, 16'h0, 1'b0, 1'b0,
              16'h1800, 16'h0, 16'h0800, 16'h0);
        drain();
        chk("basic_ovf", 80'(bus.ovf), 80'd0);

        // Mixed modes back to back.
        issue("fwd", 16'h0, 16'h0, 16'h0400, 16'h0, 16'h0, 16'h7FFF, 1'b0, 1'b0,
              16'h0, 16'h0400, 16'h0, 16'hFC00);
        issue("inv", 16'h0, 16'h0, 16'h0400, 16'h0, 16'h0, 16'h7FFF, 1'b1, 1'b0,
              16'h0, 16'hFC00, 16'h0, 16'h0400);
        issue("inv_wmin", 16'h0, 16'h0, 16'h0400, 16'h0, 16'h0, 16'h8000, 1'b1, 1'b0,
              16'h0, 16'h0400, 16'h0, 16'hFC00);
        issue("scale_rnd", 16'h0003, 16'hFFFD, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1,
              16'h0002, 16'hFFFF, 16'h0002, 16'hFFFF);
        drain();
        chk("modes_ovf", 80'(bus.ovf), 80'd0);

        issue("pos_sat", 16'h7000, 16'h0, 16'h7000, 16'h0, 16'h7FFF, 16'h0, 1'b0, 1'b0,
              16'h7FFF, 16'h0, 16'h0001, 16'h0);
        drain();
        chk("pos_sat_ovf", 80'(bus.ovf), 80'd1);
        pulse_clr();
        chk("ovf_clr", 80'(bus.ovf), 80'd0);
        issue("pos_scaled", 16'h7000, 16'h0, 16'h7000, 16'h0, 16'h7FFF, 16'h0, 1'b0, 1'b1,
              16'h7000, 16'h0, 16'h0001, 16'h0);
        drain();
        chk("pos_scaled_ovf", 80'(bus.ovf), 80'd0);

        issue("neg_sat", 16'h8000, 16'h0, 16'h7000, 16'h0, 16'h8000, 16'h0, 1'b0, 1'b0,
              16'h8000, 16'h0, 16'hF000, 16'h0);
        drain();
        chk("neg_sat_ovf", 80'(bus.ovf), 80'd1);
        // Clear lands on the same edge the clipping sample leaves S4.
        issue("neg_sat2", 16'h8000, 16'h0, 16'h7000, 16'h0, 16'h8000, 16'h0, 1'b0, 1'b0,
              16'h8000, 16'h0, 16'hF000, 16'h0);
        step(); step(); step();
        pulse_clr();
        chk("ovf_set_wins", 80'(bus.ovf), 80'd1);
        drain();
        pulse_clr();
        chk("ovf_clr2", 80'(bus.ovf), 80'd0);
        // Inputs still hold a clipping vector while in_valid is low.
        for (int i = 0; i < 6; i++) step();
        chk("bubble_no_ovf", 80'(bus.ovf), 80'd0);

        for (int k = 1; k <= 5; k++)
            issue($sformatf("stall%0d", k), 16'(k << 12), 16'(k), 16'(k << 8), 16'h0, 16'h7FFF, 16'h0,
                  1'b0, 1'b0, 16'((k << 12) + (k << 8)), 16'(k), 16'((k << 12) - (k << 8)), 16'(k));
        bus.en = 1'b0;
        bus.in_valid = 1'b1;
        bus.ar = 16'h5555;  bus.br = 16'h7777;  bus.wr = 16'h8000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_freeze", {bus.out_valid, bus.xr, bus.xi, bus.yr, bus.yi},
                {1'b1, 16'h1100, 16'h0001, 16'h0F00, 16'h0001});
        end
        bus.en = 1'b1;
        bus.in_valid = 1'b0;
        issue("stall6", 16'h6000, 16'h0006, 16'h0600, 16'h0, 16'h7FFF, 16'h0, 1'b0, 1'b0,
              16'h6600, 16'h0006, 16'h5A00, 16'h0006);
        drain();
        chk("stall_ovf", 80'(bus.ovf), 80'd0);

        issue("pre_rst_sat", 16'h8000, 16'h0, 16'h7000, 16'h0, 16'h8000, 16'h0, 1'b0, 1'b0,
              16'h8000, 16'h0, 16'hF000, 16'h0);
        drain();
        chk("pre_rst_ovf", 80'(bus.ovf), 80'd1);
        for (int k = 1; k <= 4; k++)
            issue($sformatf("flight%0d", k), 16'(k << 12), 16'(k), 16'(k << 8), 16'h0, 16'h7FFF, 16'h0,
                  1'b0, 1'b0, 16'((k << 12) + (k << 8)), 16'(k), 16'((k << 12) - (k << 8)), 16'(k));
        step();
        #1 rst_n = 1'b0;
        #1;
        chk("mid_reset", {bus.out_valid, bus.ovf, bus.xr, bus.xi, bus.yr, bus.yi}, 80'd0);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        issue("post_rst", 16'h0100, 16'h0200, 16'h0040, 16'h0, 16'h7FFF, 16'h0, 1'b0, 1'b0,
              16'h0140, 16'h0200, 16'h00C0, 16'h0200);
        drain();
        for (int i = 0; i < 8; i++) step();
        chk("post_rst_ovf", 80'(bus.ovf), 80'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
